dbg_bus_sched: RTL and testbench
================================

Name: dbg_bus_sched

Overview:
- Sequences the debug module's access to the core's shared memory bus and controls the halt and reset handshakes with the pipeline.
- Sits between the debug module (halt/reset/op requests, memory write/addr/data) and the core/memory interconnect.
- Stalls the pipeline, waits for it to drain, grants the memory port to the debugger, and returns the port to the CPU on release.
- Also stretches a debug reset request into a fixed-length core reset pulse.

Parameters:
- DRAIN_TIMEOUT, 16: max cycles to wait for cpu_busy_i low after hold; 1..255.
- RESET_CYCLES, 4: length of core_rst_o pulse in cycles; 1..255.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- dm_halt_req_i  in  1  debugger requests core halt (level).
- dm_reset_req_i  in  1  debugger requests core reset (level).
- dm_op_req_i  in  1  debugger memory access in progress (level).
- dm_mem_we_i  in  1  debugger write enable.
- dm_mem_addr_i  in  32  debugger address.
- dm_mem_wdata_i  in  32  debugger write data.
- dm_mem_rdata_o  out  32  read data to debugger.
- cpu_mem_we_i  in  1  CPU write enable.
- cpu_mem_addr_i  in  32  CPU address.
- cpu_mem_wdata_i  in  32  CPU write data.
- cpu_mem_rdata_o  out  32  read data to CPU.
- cpu_busy_i  in  1  pipeline has outstanding bus transaction.
- mem_we_o  out  1  shared port write enable.
- mem_addr_o  out  32  shared port address.
- mem_wdata_o  out  32  shared port write data.
- mem_rdata_i  in  32  shared port read data.
- hold_o  out  1  pipeline stall/halt.
- core_rst_o  out  1  core reset pulse, active-high.
- dbg_grant_o  out  1  debugger owns shared port.
- drain_timeout_o  out  1  sticky; drain wait expired.

Behaviour:
- Reset values: hold_o=0, core_rst_o=0, dbg_grant_o=0, drain_timeout_o=0, state=IDLE, all counters 0.
- Reset is asynchronous assert, synchronous release.
- Mux is combinational on dbg_grant_o:
  - grant=1: mem_* driven from dm_*.
  - grant=0: mem_* driven from cpu_*.
  - dm_mem_rdata_o and cpu_mem_rdata_o both equal mem_rdata_i.
  - mem_we_o is gated by grant: the CPU write is forced to 0 while grant=1; the DM write is ignored while grant=0.
- FSM states: IDLE, DRAIN, GRANT, RELEASE, RESET.
  - IDLE: hold_o=0. dm_reset_req_i=1 -> RESET (priority). Else dm_halt_req_i|dm_op_req_i -> DRAIN, clearing the drain counter.
  - DRAIN: hold_o=1. Counter increments each cycle.
    - cpu_busy_i=0 -> GRANT.
    - Counter reaches DRAIN_TIMEOUT-1 with busy still 1 -> GRANT and set drain_timeout_o.
    - Both requests deasserted -> RELEASE.
  - GRANT: hold_o=1, dbg_grant_o=1. Stays while dm_halt_req_i|dm_op_req_i. Both low -> RELEASE.
  - RELEASE: one cycle. hold_o=1, dbg_grant_o=0. Then IDLE, with hold_o dropping 1 cycle after grant, so the CPU never sees port ownership and run at the same edge.
  - RESET: core_rst_o=1, hold_o=1, grant=0, for exactly RESET_CYCLES cycles. Then:
    - dm_reset_req_i still high: wait in RESET with core_rst_o=0 until it falls (pulse is not re-triggered by a held level).
    - Otherwise go to DRAIN if a halt/op request is pending, else IDLE.
- dm_reset_req_i rising edge in DRAIN, GRANT or RELEASE -> RESET next cycle; grant drops immediately.
- Latency: request to grant is 2 cycles minimum (IDLE->DRAIN->GRANT with busy=0). Release to CPU ownership is 1 cycle; to hold_o=0 is 2 cycles.
- drain_timeout_o clears only on rst or on the next successful drain (busy=0 before timeout).
- dbg_grant_o, hold_o and core_rst_o are registered outputs.
- Requests asserted during rst are sampled on the first cycle after release.

Test Plan:
- rst pulse mid-GRANT -> all outputs 0 asynchronously; state IDLE; mux selects CPU (mem_addr_o=cpu_mem_addr_i).
- dm_halt_req_i=1, cpu_busy_i=0 -> hold_o=1 at cycle 1, dbg_grant_o=1 at cycle 2; dm_mem_addr_i=0x1000, we=1 -> mem_addr_o=0x1000, mem_we_o=1; cpu_mem_we_i=1 blocked.
- cpu_busy_i held 1, DRAIN_TIMEOUT=16 -> grant at cycle 17, drain_timeout_o=1; next halt with busy=0 clears it.
- Halt then release: dbg_grant_o falls 1 cycle after request drop, hold_o 1 cycle later; CPU address appears on mem_addr_o when grant=0.
- dm_reset_req_i held 10 cycles, RESET_CYCLES=4 -> core_rst_o high exactly 4 cycles, single pulse; FSM to IDLE after request falls.
- dm_reset_req_i asserted during GRANT -> grant drops next cycle, core_rst_o pulse follows; pending dm_halt_req_i=1 -> DRAIN after pulse.

Source files
------------

// File: rtl/dbg_bus_sched.sv
// Debug bus scheduler: stalls and drains the pipeline, hands the shared memory
// port to the debugger, and stretches debug reset requests into a core reset pulse.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | CPU owns the port, pipeline running
// DRAIN   | pipeline held, waiting for outstanding CPU transaction to finish
// GRANT   | debugger owns the port, pipeline held
// RELEASE | port back to CPU, pipeline still held for one cycle
// RESET   | core reset pulse, then wait for the reset request to fall
module dbg_bus_sched #(
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned RESET_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_halt_req_i,
    input  logic        dm_reset_req_i,
    input  logic        dm_op_req_i,
    input  logic        dm_mem_we_i,
    input  logic [31:0] dm_mem_addr_i,
    input  logic [31:0] dm_mem_wdata_i,
    output logic [31:0] dm_mem_rdata_o,
    input  logic        cpu_mem_we_i,
    input  logic [31:0] cpu_mem_addr_i,
    input  logic [31:0] cpu_mem_wdata_i,
    output logic [31:0] cpu_mem_rdata_o,
    input  logic        cpu_busy_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        hold_o,
    output logic        core_rst_o,
    output logic        dbg_grant_o,
    output logic        drain_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_GRANT,
        S_RELEASE,
        S_RESET
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0] RESET_LAST = 8'(RESET_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic       rst_wait_q, rst_wait_d;
    logic       reset_req_q;
    logic       timeout_q, timeout_d;
    logic       hold_q, grant_q, core_rst_q;
    logic       dbg_req;
    logic       reset_rise;

    assign dbg_req    = dm_halt_req_i | dm_op_req_i;
    assign reset_rise = dm_reset_req_i & ~reset_req_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        rst_wait_d  = rst_wait_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (dm_reset_req_i) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = 8'd0;
                    rst_wait_d = 1'b0;
                end else if (dbg_req) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 8'd0;
                end
            end
            S_DRAIN: begin
                if (reset_rise) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = 8'd0;
                    rst_wait_d = 1'b0;
                end else if (!dbg_req) begin
                    state_d = S_RELEASE;
                end else if (!cpu_busy_i) begin
                    state_d   = S_GRANT;
                    timeout_d = 1'b0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    // Give up on the drain; the debugger gets the port anyway.
                    state_d   = S_GRANT;
                    timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            S_GRANT: begin
                if (reset_rise) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = 8'd0;
                    rst_wait_d = 1'b0;
                end else if (!dbg_req) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (reset_rise) begin
                    state_d    = S_RESET;
                    rst_cnt_d  = 8'd0;
                    rst_wait_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESET: begin
                if (!rst_wait_q && (rst_cnt_q != RESET_LAST)) begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end else if (dm_reset_req_i) begin
                    // A held request must not retrigger the pulse.
                    rst_wait_d = 1'b1;
                end else if (dbg_req) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 8'd0;
                    rst_wait_d  = 1'b0;
                end else begin
                    state_d    = S_IDLE;
                    rst_wait_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 8'd0;
            rst_cnt_q   <= 8'd0;
            rst_wait_q  <= 1'b0;
            reset_req_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= 1'b0;
            grant_q     <= 1'b0;
            core_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            rst_wait_q  <= rst_wait_d;
            reset_req_q <= dm_reset_req_i;
            timeout_q   <= timeout_d;
            hold_q      <= (state_d != S_IDLE);
            grant_q     <= (state_d == S_GRANT);
            core_rst_q  <= (state_d == S_RESET) && !rst_wait_d;
        end
    end

    assign hold_o          = hold_q;
    assign dbg_grant_o     = grant_q;
    assign core_rst_o      = core_rst_q;
    assign drain_timeout_o = timeout_q;

    // Port mux; the non-owner's write enable never reaches the memory.
    assign mem_we_o        = grant_q ? dm_mem_we_i    : cpu_mem_we_i;
    assign mem_addr_o      = grant_q ? dm_mem_addr_i  : cpu_mem_addr_i;
    assign mem_wdata_o     = grant_q ? dm_mem_wdata_i : cpu_mem_wdata_i;
    assign dm_mem_rdata_o  = mem_rdata_i;
    assign cpu_mem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_dbg_bus_sched.sv
// Directed bench for dbg_bus_sched: halt/grant handshake, drain timeout,
// release ordering, async reset and core reset pulse stretching.
module tb_dbg_bus_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_halt_req_i, dm_reset_req_i, dm_op_req_i, dm_mem_we_i;
    logic [31:0] dm_mem_addr_i, dm_mem_wdata_i, dm_mem_rdata_o;
    logic        cpu_mem_we_i;
    logic [31:0] cpu_mem_addr_i, cpu_mem_wdata_i, cpu_mem_rdata_o;
    logic        cpu_busy_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        hold_o, core_rst_o, dbg_grant_o, drain_timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbg_bus_sched #(.DRAIN_TIMEOUT(16), .RESET_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .dm_halt_req_i   (dm_halt_req_i),
        .dm_reset_req_i  (dm_reset_req_i),
        .dm_op_req_i     (dm_op_req_i),
        .dm_mem_we_i     (dm_mem_we_i),
        .dm_mem_addr_i   (dm_mem_addr_i),
        .dm_mem_wdata_i  (dm_mem_wdata_i),
        .dm_mem_rdata_o  (dm_mem_rdata_o),
        .cpu_mem_we_i    (cpu_mem_we_i),
        .cpu_mem_addr_i  (cpu_mem_addr_i),
        .cpu_mem_wdata_i (cpu_mem_wdata_i),
        .cpu_mem_rdata_o (cpu_mem_rdata_o),
        .cpu_busy_i      (cpu_busy_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .hold_o          (hold_o),
        .core_rst_o      (core_rst_o),
        .dbg_grant_o     (dbg_grant_o),
        .drain_timeout_o (drain_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        int rises;
        logic prev;

        rst             = 1'b1;
        dm_halt_req_i   = 1'b0;
        dm_reset_req_i  = 1'b0;
        dm_op_req_i     = 1'b0;
        dm_mem_we_i     = 1'b0;
        dm_mem_addr_i   = 32'h0;
        dm_mem_wdata_i  = 32'h0;
        cpu_mem_we_i    = 1'b0;
        cpu_mem_addr_i  = 32'h0000_2000;
        cpu_mem_wdata_i = 32'h1234_5678;
        cpu_busy_i      = 1'b0;
        mem_rdata_i     = 32'hA5A5_0001;

        // Reset state
        #2;
        chk("rst_hold", 32'(hold_o), 32'd0);
        chk("rst_grant", 32'(dbg_grant_o), 32'd0);
        chk("rst_core_rst", 32'(core_rst_o), 32'd0);
        chk("rst_timeout", 32'(drain_timeout_o), 32'd0);
        chk("rst_mux_addr", mem_addr_o, 32'h0000_2000);
        #10;
        rst = 1'b0;

        // Halt with idle pipeline: hold at cycle 1, grant at cycle 2
        dm_halt_req_i  = 1'b1;
        dm_mem_addr_i  = 32'h0000_1000;
        dm_mem_we_i    = 1'b1;
        dm_mem_wdata_i = 32'hDEAD_BEEF;
        cpu_mem_we_i   = 1'b1;
        #1;
        chk("cpu_owns_addr", mem_addr_o, 32'h0000_2000);
        chk("cpu_owns_we", 32'(mem_we_o), 32'd1);
        chk("dm_rdata", dm_mem_rdata_o, 32'hA5A5_0001);
        chk("cpu_rdata", cpu_mem_rdata_o, 32'hA5A5_0001);
        tick();
        chk("halt_c1_hold", 32'(hold_o), 32'd1);
        chk("halt_c1_grant", 32'(dbg_grant_o), 32'd0);
        tick();
        chk("halt_c2_grant", 32'(dbg_grant_o), 32'd1);
        chk("grant_addr", mem_addr_o, 32'h0000_1000);
        chk("grant_we", 32'(mem_we_o), 32'd1);
        chk("grant_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        dm_mem_we_i = 1'b0;
        #1;
        chk("cpu_we_blocked", 32'(mem_we_o), 32'd0);

        // Release: grant falls one cycle after request drop, hold one later
        dm_halt_req_i = 1'b0;
        tick();
        chk("rel_grant", 32'(dbg_grant_o), 32'd0);
        chk("rel_hold", 32'(hold_o), 32'd1);
        chk("rel_addr_cpu", mem_addr_o, 32'h0000_2000);
        tick();
        chk("rel_hold_drop", 32'(hold_o), 32'd0);

        // Request withdrawn during drain
        dm_op_req_i = 1'b1;
        cpu_busy_i  = 1'b1;
        tick();
        chk("abort_drain_hold", 32'(hold_o), 32'd1);
        dm_op_req_i = 1'b0;
        tick();
        chk("abort_rel_grant", 32'(dbg_grant_o), 32'd0);
        chk("abort_rel_hold", 32'(hold_o), 32'd1);
        tick();
        chk("abort_idle_hold", 32'(hold_o), 32'd0);
        chk("abort_no_timeout", 32'(drain_timeout_o), 32'd0);

        // Drain timeout: busy stuck, grant forced at cycle 17
        dm_halt_req_i = 1'b1;
        repeat (16) tick();
        chk("to_c16_grant", 32'(dbg_grant_o), 32'd0);
        chk("to_c16_flag", 32'(drain_timeout_o), 32'd0);
        tick();
        chk("to_c17_grant", 32'(dbg_grant_o), 32'd1);
        chk("to_c17_flag", 32'(drain_timeout_o), 32'd1);
        dm_halt_req_i = 1'b0;
        cpu_busy_i    = 1'b0;
        tick();
        tick();
        chk("to_idle_hold", 32'(hold_o), 32'd0);
        chk("to_sticky", 32'(drain_timeout_o), 32'd1);
        dm_halt_req_i = 1'b1;
        tick();
        chk("to_drain_still_set", 32'(drain_timeout_o), 32'd1);
        tick();
        chk("to_clear_grant", 32'(dbg_grant_o), 32'd1);
        chk("to_cleared", 32'(drain_timeout_o), 32'd0);

        // Async reset mid-GRANT, halt still asserted through reset
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(dbg_grant_o), 32'd0);
        chk("arst_hold", 32'(hold_o), 32'd0);
        chk("arst_mux_cpu", mem_addr_o, 32'h0000_2000);
        #3;
        rst = 1'b0;
        tick();
        chk("post_rst_hold", 32'(hold_o), 32'd1);
        tick();
        chk("post_rst_grant", 32'(dbg_grant_o), 32'd1);
        dm_halt_req_i = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", 32'(hold_o), 32'd0);

        // Reset request held 10 cycles: single 4-cycle pulse
        dm_reset_req_i = 1'b1;
        hi    = 0;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (core_rst_o) hi++;
            if (core_rst_o && !prev) rises++;
            prev = core_rst_o;
        end
        chk("rst_pulse_len", 32'(hi), 32'd4);
        chk("rst_pulse_count", 32'(rises), 32'd1);
        chk("rst_wait_hold", 32'(hold_o), 32'd1);
        chk("rst_wait_grant", 32'(dbg_grant_o), 32'd0);
        dm_reset_req_i = 1'b0;
        tick();
        chk("rst_to_idle_hold", 32'(hold_o), 32'd0);
        chk("rst_to_idle_core", 32'(core_rst_o), 32'd0);

        // Reset request during GRANT with halt pending -> pulse then DRAIN
        dm_halt_req_i = 1'b1;
        tick();
        tick();
        chk("g2r_grant_before", 32'(dbg_grant_o), 32'd1);
        dm_reset_req_i = 1'b1;
        tick();
        chk("g2r_grant_drop", 32'(dbg_grant_o), 32'd0);
        chk("g2r_core_rst", 32'(core_rst_o), 32'd1);
        dm_reset_req_i = 1'b0;
        repeat (3) tick();
        chk("g2r_core_rst_c4", 32'(core_rst_o), 32'd1);
        tick();
        chk("g2r_pulse_end", 32'(core_rst_o), 32'd0);
        chk("g2r_drain_hold", 32'(hold_o), 32'd1);
        chk("g2r_drain_grant", 32'(dbg_grant_o), 32'd0);
        tick();
        chk("g2r_regrant", 32'(dbg_grant_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
